refresh_scan_timer: RTL and testbench
=====================================

# refresh_scan_timer

Generates the 2-bit `refreshcounter` digit-select code that drives the anode decoder of the four-digit seven-segment display. It divides the system clock down to a per-digit refresh rate and steps the select through the four digits. It also emits a one-cycle tick whenever the select changes, so the segment-data mux can align to it. It sits directly upstream of the anode decoder and the segment mux.

## Interface
Parameters:
- `DIV_WIDTH`, 17: width of the prescaler counter.
- `DIV_MAX`, 99999: terminal prescaler count. Digit period is DIV_MAX+1 clocks (1 kHz per digit at 100 MHz). Legal range is 1 ≤ DIV_MAX ≤ 2**DIV_WIDTH−1.

Ports:
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: scan runs while high; all state freezes while low.
- `sync_clr` input, 1 bit: synchronous restart of the scan.
- `brightness` input, 4 bits: duty setting. Used only with BRIGHTNESS_PWM_EN.
- `refreshcounter` output, 2 bits: digit select. 0 is the rightmost digit, 3 the leftmost.
- `digit_tick` output, 1 bit: one-cycle pulse, high in the first cycle a new `refreshcounter` value is visible.
- `blank` output, 1 bit: when high, the downstream stage forces all anodes off.

## Operation
- State:
  - `presc` (DIV_WIDTH bits).
  - `refreshcounter` (2 bits).
  - `digit_tick` (registered).
  - `pwm_cnt` (4 bits, macro only).
  - `blank` (registered, macro only).
- Reset values (async, `rst_n`=0):
  - `presc`=0, `refreshcounter`=0, `digit_tick`=0.
  - `blank`=1 with the macro, constant 0 without it.
- Priority per clock, highest first: `sync_clr`, then `enable`, then hold.
- `sync_clr`=1:
  - `presc`←0, `refreshcounter`←0, `digit_tick`←0.
  - `pwm_cnt`←0, `blank`←1 (macro only).
  - `enable` is ignored in that cycle.
- `enable`=1 and `presc`≠DIV_MAX: `presc`←`presc`+1 and `digit_tick`←0.
- `enable`=1 and `presc`=DIV_MAX:
  - `presc`←0.
  - `refreshcounter`←`refreshcounter`+1, modulo 4, so 3 wraps to 0.
  - `digit_tick`←1.
- `enable`=0: `presc`, `refreshcounter`, `pwm_cnt` and `blank` hold, and `digit_tick`←0.
- Digit order is 0,1,2,3,0,… with no other sequence possible.
- Exactly one `digit_tick` per `refreshcounter` change. No tick while held.

## Timing
- All outputs are registered, with no combinational path from input to output.
- With `enable` high continuously from the reset release:
  - The first `digit_tick` and `refreshcounter`=1 appear after DIV_MAX+1 rising edges.
  - Later ticks follow every DIV_MAX+1 edges.
- Gating `enable` stretches the period by exactly the number of low cycles. The count resumes from the held `presc`.
- `sync_clr` takes effect on the next edge. A full period of DIV_MAX+1 enabled cycles then elapses before the next tick.
- An asynchronous reset mid-period clears the state immediately, without waiting for a clock edge.

## Configuration
- Macro: `BRIGHTNESS_PWM_EN`.
- Defined:
  - `pwm_cnt` increments modulo 16 on every enabled clock.
  - `blank`←(`pwm_cnt` ≥ `brightness`), registered with a one-cycle lag.
  - `brightness`=0 gives `blank` permanently high after reset.
  - `brightness`=15 gives `blank` high 1 cycle in 16.
  - `blank` holds while `enable`=0.
- Undefined:
  - `brightness` is ignored, and `pwm_cnt` and its logic are absent.
  - `blank` is constant 0.
  - Port list is identical in both builds.

## Test plan
All scenarios use DIV_WIDTH=4 and DIV_MAX=3.
- Reset then `enable`=1: `refreshcounter` steps 0→1→2→3→0 every 4 clocks. `digit_tick` is high exactly on cycles 4, 8, 12, 16 after release.
- `enable` low for 5 cycles with `presc`=2: outputs hold, no tick. The next tick arrives 5 cycles later than in the ungated run.
- `sync_clr` asserted with `refreshcounter`=2, `presc`=3 and `enable`=1: next cycle `refreshcounter`=0, no tick. The next tick comes 4 enabled clocks later.
- Assert `rst_n`=0 between clock edges mid-period: `refreshcounter`=0 and `digit_tick`=0 immediately, without a clock edge.
- With BRIGHTNESS_PWM_EN and `brightness`=4: `blank` is low 4 and high 12 of every 16 enabled cycles. With `brightness`=0, `blank` stays 1.
- Without BRIGHTNESS_PWM_EN: `blank`=0 for every `brightness` value, including during reset.

Source files
------------

// File: rtl/refresh_scan_timer.sv
// refresh_scan_timer
// Divides the system clock to a per-digit refresh period of DIV_MAX+1 clocks
// and steps a 2-bit digit select 0,1,2,3,0,... for the four-digit display.
// A registered one-cycle digit_tick marks the first cycle of each new select.
// Optional feature macro: BRIGHTNESS_PWM_EN. When defined, a 16-step PWM drives
// a registered blank output from the brightness setting. When undefined,
// blank is tied low and brightness is ignored.
module refresh_scan_timer #(
    parameter int DIV_WIDTH = 17,
    parameter int DIV_MAX   = 99999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       sync_clr,
    input  logic [3:0] brightness,
    output logic [1:0] refreshcounter,
    output logic       digit_tick,
    output logic       blank
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] presc_reg;
    logic [DIV_WIDTH-1:0] presc_next;
    logic [1:0]           digit_reg;
    logic [1:0]           digit_next;
    logic                 tick_reg;
    logic                 tick_next;
    logic                 period_end;

    assign period_end = (presc_reg == DIV_LAST);

    // Scan next-state: restart beats enable, enable beats hold; the tick is
    // only ever set on the cycle the digit select advances.
    always_comb begin
        presc_next = presc_reg;
        digit_next = digit_reg;
        tick_next  = 1'b0;
        if (sync_clr) begin
            presc_next = '0;
            digit_next = 2'd0;
        end else if (enable) begin
            if (period_end) begin
                presc_next = '0;
                digit_next = digit_reg + 2'd1;
                tick_next  = 1'b1;
            end else begin
                presc_next = presc_reg + DIV_ONE;
            end
        end
    end

    // Scan state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            digit_reg <= 2'd0;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            digit_reg <= digit_next;
            tick_reg  <= tick_next;
        end
    end

    assign refreshcounter = digit_reg;
    assign digit_tick     = tick_reg;

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] pwm_cnt_reg;
    logic [3:0] pwm_cnt_next;
    logic       blank_reg;
    logic       blank_next;

    // PWM next-state: free-running 16-step count on enabled clocks; blank is
    // the comparison of the current count, so it lags the count by one cycle.
    always_comb begin
        pwm_cnt_next = pwm_cnt_reg;
        blank_next   = blank_reg;
        if (sync_clr) begin
            pwm_cnt_next = 4'd0;
            blank_next   = 1'b1;
        end else if (enable) begin
            pwm_cnt_next = pwm_cnt_reg + 4'd1;
            blank_next   = (pwm_cnt_reg >= brightness);
        end
    end

    // PWM registers; display starts blanked until the first comparison
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= 4'd0;
            blank_reg   <= 1'b1;
        end else begin
            pwm_cnt_reg <= pwm_cnt_next;
            blank_reg   <= blank_next;
        end
    end

    assign blank = blank_reg;
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign blank             = 1'b0;
`endif

endmodule

// File: tb/tb_refresh_scan_timer.sv
// tb_refresh_scan_timer
// Scoreboard bench for refresh_scan_timer with DIV_WIDTH=4, DIV_MAX=3.
// Expected outputs are pushed when a cycle's stimulus is driven and popped
// and compared one clock later; blank expectations follow BRIGHTNESS_PWM_EN.
module tb_refresh_scan_timer;

    localparam int DIV_WIDTH = 4;
    localparam int DIV_MAX   = 3;
    localparam int PERIOD    = DIV_MAX + 1;

`ifdef BRIGHTNESS_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] rc;
        logic       tick;
        logic       blank;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       sync_clr;
    logic [3:0] brightness;
    logic [1:0] refreshcounter;
    logic       digit_tick;
    logic       blank;

    int checks;
    int errors;

    exp_t exp_q[$];

    // reference state of the scan and PWM
    int   m_presc;
    int   m_rc;
    logic m_tick;
    int   m_pwm;
    logic m_blank;

    refresh_scan_timer #(
        .DIV_WIDTH(DIV_WIDTH),
        .DIV_MAX  (DIV_MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sync_clr      (sync_clr),
        .brightness    (brightness),
        .refreshcounter(refreshcounter),
        .digit_tick    (digit_tick),
        .blank         (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_rc    = 0;
        m_tick  = 1'b0;
        m_pwm   = 0;
        m_blank = PWM_ON;
        exp_q.delete();
    endtask

    // Advance the reference by one clock with the stimulus being driven
    task automatic model_step(input logic en, input logic clr, input logic [3:0] br);
        if (clr) begin
            m_presc = 0;
            m_rc    = 0;
            m_tick  = 1'b0;
            m_pwm   = 0;
            m_blank = PWM_ON;
        end else if (en) begin
            if (m_presc == DIV_MAX) begin
                m_presc = 0;
                m_rc    = (m_rc + 1) % 4;
                m_tick  = 1'b1;
            end else begin
                m_presc = m_presc + 1;
                m_tick  = 1'b0;
            end
            if (PWM_ON) begin
                m_blank = (m_pwm >= int'(br));
                m_pwm   = (m_pwm + 1) % 16;
            end
        end else begin
            m_tick = 1'b0;
        end
    endtask

    // One clock: drive at negedge, push expectation, compare just after posedge
    task automatic step(input logic en, input logic clr, input logic [3:0] br);
        exp_t e;
        exp_t o;
        @(negedge clk);
        enable     = en;
        sync_clr   = clr;
        brightness = br;
        model_step(en, clr, br);
        e.rc    = 2'(m_rc);
        e.tick  = m_tick;
        e.blank = m_blank;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        chk("rc", int'(refreshcounter), int'(o.rc));
        chk("tick", int'(digit_tick), int'(o.tick));
        chk("blank", int'(blank), int'(o.blank));
        $display("cyc en=%0d clr=%0d br=%0d rc=%0d tick=%0d blank=%0d",
                 en, clr, br, refreshcounter, digit_tick, blank);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        enable   = 1'b0;
        sync_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_rc", int'(refreshcounter), 0);
        chk("rst_tick", int'(digit_tick), 0);
        chk("rst_blank", int'(blank), int'(PWM_ON));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int cyc;
    int lows;

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b1;
        enable     = 1'b0;
        sync_clr   = 1'b0;
        brightness = 4'd0;

        // 1: free run from reset, ticks on cycles 4,8,12,16
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 4'd7);
            chk("run_tick_pos", int'(digit_tick), (k % PERIOD == 0) ? 1 : 0);
            chk("run_rc_pos", int'(refreshcounter), (k / PERIOD) % 4);
        end

        // 2: gate enable low for 5 cycles with presc=2
        do_reset();
        step(1'b1, 1'b0, 4'd7);
        step(1'b1, 1'b0, 4'd7);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 4'd7);
            chk("gate_hold_rc", int'(refreshcounter), 0);
            chk("gate_no_tick", int'(digit_tick), 0);
        end
        cyc = 7;
        while (digit_tick !== 1'b1 && cyc < 20) begin
            step(1'b1, 1'b0, 4'd7);
            cyc++;
        end
        chk("gate_tick_cycle", cyc, PERIOD + 5);

        // 3: sync_clr at rc=2, presc=3 with enable high
        do_reset();
        for (int k = 0; k < 11; k++) step(1'b1, 1'b0, 4'd7);
        chk("pre_clr_rc", int'(refreshcounter), 2);
        step(1'b1, 1'b1, 4'd7);
        chk("clr_rc", int'(refreshcounter), 0);
        chk("clr_tick", int'(digit_tick), 0);
        cyc = 0;
        do begin
            step(1'b1, 1'b0, 4'd7);
            cyc++;
        end while (digit_tick !== 1'b1 && cyc < 12);
        chk("clr_next_tick", cyc, PERIOD);
        chk("clr_next_rc", int'(refreshcounter), 1);

        // 4: asynchronous reset between edges, right after a tick
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 4'd7);
        chk("pre_async_tick", int'(digit_tick), 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rc", int'(refreshcounter), 0);
        chk("async_tick", int'(digit_tick), 0);
        chk("async_blank", int'(blank), int'(PWM_ON));
        @(negedge clk);
        rst_n = 1'b1;

        // 5: brightness=4 over 32 enabled cycles
        do_reset();
        lows = 0;
        for (int k = 0; k < 32; k++) begin
            step(1'b1, 1'b0, 4'd4);
            if (blank === 1'b0) lows++;
        end
        chk("pwm4_low_count", lows, PWM_ON ? 8 : 32);

        // 6: brightness=0 keeps blank at its idle level
        do_reset();
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 4'd0);
            if (blank === 1'b0) lows++;
        end
        chk("pwm0_low_count", lows, PWM_ON ? 0 : 20);

        // 7: brightness=15 and random sweep with random gating and restarts
        do_reset();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 4'd15);
        for (int k = 0; k < 40; k++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
